// File: rtl/output_pulse_conditioner.sv
// output_pulse_conditioner: stretches single-cycle strobes into registered pulses with minimum high width and low gap.
// Define OUTPUT_PULSE_PENDING_EN to queue events that arrive while busy instead of dropping them.
module output_pulse_conditioner #(
  parameter int HIGH_CYCLES = 6,
  parameter int GAP_CYCLES  = 6,
  parameter int CNT_WIDTH   = 8,
  parameter int PEND_WIDTH  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic op,
  output logic busy,
  output logic dropped
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  localparam logic [CNT_WIDTH-1:0] H_LD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] G_LD = CNT_WIDTH'(GAP_CYCLES - 1);
  if (HIGH_CYCLES < 1 || HIGH_CYCLES >= 2**CNT_WIDTH || GAP_CYCLES < 1 ||
      GAP_CYCLES >= 2**CNT_WIDTH || PEND_WIDTH < 1) begin : g_bad_params
    $error("output_pulse_conditioner: illegal parameter combination");
  end
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic op_q, op_d, busy_q, busy_d, dropped_q, dropped_d;
  logic cnt_zero, last_gap, busy_ev, work;
  assign cnt_zero = cnt_q == '0;
  assign last_gap = state_q == GAP && cnt_zero;
  // a trig on the final gap cycle starts the next pulse, so it is never a busy event
  assign busy_ev  = trig && (state_q == HIGH || (state_q == GAP && !cnt_zero));
`ifdef OUTPUT_PULSE_PENDING_EN
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic pend_full;
  assign pend_full = &pend_q;
  always_comb begin
    pend_d = pend_q;
    if (busy_ev && !pend_full) pend_d = pend_q + 1'b1;
    else if (last_gap && !trig && pend_q != '0) pend_d = pend_q - 1'b1;
  end
  assign work      = trig || pend_q != '0;
  assign dropped_d = busy_ev && pend_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend_q <= '0;
    else pend_q <= pend_d;
`else
  assign work      = trig;
  assign dropped_d = busy_ev;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (trig) begin
        state_d = HIGH;
        cnt_d   = H_LD;
        op_d    = 1'b1;
      end
      HIGH: if (!cnt_zero) cnt_d = cnt_q - 1'b1;
      else begin
        state_d = GAP;
        cnt_d   = G_LD;
        op_d    = 1'b0;
      end
      GAP: if (!cnt_zero) cnt_d = cnt_q - 1'b1;
      else if (work) begin
        state_d = HIGH;
        cnt_d   = H_LD;
        op_d    = 1'b1;
      end else state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        op_d    = 1'b0;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  assign op      = op_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;
endmodule

// File: tb/tb_output_pulse_conditioner.sv
// tb_output_pulse_conditioner: table-driven, scoreboarded bench over default, PEND_WIDTH=2 and 1/1-cycle instances.
module tb_output_pulse_conditioner;
  typedef struct {logic trig, op, busy, drop;} vec_t;
  logic clk = 0, rst = 0, trig = 0;
  int sel = 0;
  logic [2:0] t, op_w, busy_w, drop_w;
  vec_t tbl[$], sb[$];
  int tq[$], sq[$], dq[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign t = trig ? 3'(3'b001 << sel) : 3'b000;
  output_pulse_conditioner dut0 (.clk(clk), .rst(rst), .trig(t[0]), .op(op_w[0]), .busy(busy_w[0]), .dropped(drop_w[0]));
  output_pulse_conditioner #(.PEND_WIDTH(2)) dut1 (.clk(clk), .rst(rst), .trig(t[1]), .op(op_w[1]), .busy(busy_w[1]), .dropped(drop_w[1]));
  output_pulse_conditioner #(.HIGH_CYCLES(1), .GAP_CYCLES(1)) dut2 (.clk(clk), .rst(rst), .trig(t[2]), .op(op_w[2]), .busy(busy_w[2]), .dropped(drop_w[2]));
  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask
  function automatic bit has(int q[$], int x);
    foreach (q[i]) if (q[i] == x) return 1;
    return 0;
  endfunction
  // expected waveform derived from pulse start times: high h cycles from each start, busy until last start + h + g
  task automatic build(int n, int h, int g);
    vec_t v;
    int busy_end;
    busy_end = sq[sq.size()-1] + h + g;
    tbl.delete();
    for (int i = 0; i < n; i++) begin
      v.trig = has(tq, i);
      v.op = 1'b0;
      foreach (sq[k]) if (i >= sq[k] && i < sq[k] + h) v.op = 1'b1;
      v.busy = i < busy_end;
      v.drop = has(dq, i);
      tbl.push_back(v);
    end
  endtask
  task automatic step(vec_t v, string tag, int i);
    vec_t e;
    @(negedge clk);
    trig = v.trig;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("%s[%0d] op", tag, i), op_w[sel], e.op);
    chk($sformatf("%s[%0d] busy", tag, i), busy_w[sel], e.busy);
    chk($sformatf("%s[%0d] dropped", tag, i), drop_w[sel], e.drop);
  endtask
  task automatic run(string tag);
    foreach (tbl[i]) step(tbl[i], tag, i);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    trig = 0;
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trig = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      chk("reset op", op_w[0], 1'b0);
      chk("reset busy", busy_w[0], 1'b0);
      chk("reset dropped", drop_w[0], 1'b0);
    end
    do_reset();
    v = '{1'b1, 1'b1, 1'b1, 1'b0};
    step(v, "mid_high", 0);
    v = '{1'b0, 1'b1, 1'b1, 1'b0};
    step(v, "mid_high", 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("async reset op", op_w[0], 1'b0);
    chk("async reset busy", busy_w[0], 1'b0);
    do_reset();
    tq = '{0}; sq = '{0}; dq.delete();
    build(14, 6, 6);
    run("single");
    do_reset();
    tq = '{0, 12}; sq = '{0, 12}; dq.delete();
    build(26, 6, 6);
    run("b2b");
    do_reset();
`ifdef OUTPUT_PULSE_PENDING_EN
    tq = '{0, 2, 3, 4}; sq = '{0, 12, 24, 36}; dq.delete();
    build(50, 6, 6);
`else
    tq = '{0, 2, 3, 4}; sq = '{0}; dq = '{2, 3, 4};
    build(14, 6, 6);
`endif
    run("busy_trig");
    sel = 1;
    do_reset();
`ifdef OUTPUT_PULSE_PENDING_EN
    tq = '{0, 1, 2, 3, 4, 5}; sq = '{0, 12, 24, 36}; dq = '{4, 5};
    build(50, 6, 6);
`else
    tq = '{0, 1, 2, 3, 4, 5}; sq = '{0}; dq = '{1, 2, 3, 4, 5};
    build(14, 6, 6);
`endif
    run("sat");
    sel = 2;
    do_reset();
`ifdef OUTPUT_PULSE_PENDING_EN
    tq = '{0, 1, 2, 3, 4, 5, 6, 7}; sq = '{0, 2, 4, 6, 8, 10, 12, 14}; dq.delete();
    build(18, 1, 1);
`else
    tq = '{0, 1, 2, 3, 4, 5, 6, 7}; sq = '{0, 2, 4, 6}; dq = '{1, 3, 5, 7};
    build(10, 1, 1);
`endif
    run("fast");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
